mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL use one clock, `clk`; reset is `rst`, asynchronous and active-high.
REQ-002 The block SHALL have these ports, clock and reset first (name, direction, width, meaning):
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `imem_addr`  in  32  instruction-fetch address.
- `imem_rmask`  in  4  fetch byte-read mask; nonzero = request pending.
- `imem_rdata`  out  32  fetch read data.
- `imem_resp`  out  1  fetch complete, one-cycle pulse.
- `dmem_addr`  in  32  data address.
- `dmem_rmask`  in  4  data byte-read mask.
- `dmem_wmask`  in  4  data byte-write mask.
- `dmem_wdata`  in  32  data write data.
- `dmem_rdata`  out  32  data read data.
- `dmem_resp`  out  1  data access complete, one-cycle pulse.
- `mem_addr`  out  32  shared-port address.
- `mem_rmask`  out  4  shared-port read mask.
- `mem_wmask`  out  4  shared-port write mask.
- `mem_wdata`  out  32  shared-port write data.
- `mem_rdata`  in  32  shared-port read data.
- `mem_resp`  in  1  shared-port completion, one-cycle pulse.

Function
REQ-003 A requester SHALL be pending when its masks are nonzero: I = `imem_rmask`!=0; D = (`dmem_rmask`|`dmem_wmask`)!=0.
REQ-004 Requesters SHALL hold address, masks and wdata stable until their resp cycle; the arbiter SHALL NOT rely on them after grant.
REQ-005 The FSM SHALL have states IDLE, ISSUE, WAIT; the block SHALL allow at most one outstanding shared-port access.
REQ-006 In IDLE with a pending request, the block SHALL grant one requester, capture its addr, masks and wdata into registers, and go to ISSUE at the next edge.
- Captured imem masks are rmask = `imem_rmask`, wmask = 0.
REQ-007 Tie-break SHALL be round-robin via a flop `last_grant` (I/D); when both are pending, grant the requester not equal to `last_grant`; `last_grant` updates on each grant.
REQ-008 In ISSUE, `mem_addr`, `mem_rmask`, `mem_wmask` and `mem_wdata` SHALL drive the captured values for exactly one cycle; next state WAIT, or IDLE if `mem_resp`=1 in that cycle.
REQ-009 In IDLE and WAIT, `mem_rmask` and `mem_wmask` SHALL be 0; `mem_addr` and `mem_wdata` SHALL hold the captured values.
REQ-010 In WAIT, `mem_resp`=1 SHALL complete the access and return to IDLE at the next edge; otherwise the block SHALL stay in WAIT with no timeout.
REQ-011 On completion (ISSUE or WAIT with `mem_resp`=1), the granted side's resp SHALL be 1 combinationally in that cycle, with its rdata = `mem_rdata`; the other side's resp SHALL be 0.
REQ-012 `imem_rdata` and `dmem_rdata` SHALL equal `mem_rdata` in all cycles, and each resp SHALL be 0 outside completion cycles.
REQ-013 `mem_resp` in IDLE SHALL be ignored: no resp output, no state change.
REQ-014 A request arriving while the other side is in flight SHALL wait and be granted in the first IDLE cycle after completion.
- Minimum request-to-resp latency is 2 cycles: grant cycle (IDLE), then ISSUE.
REQ-015 The block SHALL forward a D request with both `dmem_rmask` and `dmem_wmask` nonzero unmodified; it SHALL NOT check the masks.

Reset
REQ-016 While `rst`=1, and immediately on assertion, the block SHALL hold: state=IDLE; `last_grant`=I (first tie goes to D); captured regs=0; all mem masks 0; `mem_addr`=0; `mem_wdata`=0; both resps 0.
REQ-017 Reset asserted mid-access (ISSUE or WAIT) SHALL abandon the access; a later `mem_resp` for it SHALL be ignored per REQ-013.

Verification
REQ-018 Single fetch: `imem_addr`=0x6000_0000, `imem_rmask`=0xF at cycle 0; memory responds 3 cycles after ISSUE with 0x0000_0013.
- `mem_rmask`=0xF in cycle 1 only.
- `imem_resp`=1 with `imem_rdata`=0x0000_0013 in cycle 4; `dmem_resp` stays 0.
REQ-019 Simultaneous I and D after reset: D is granted first.
- D: `dmem_wmask`=0x3, addr 0x100, wdata 0xBEEF.
- `mem_wmask`=0x3, `mem_addr`=0x100 in the first ISSUE.
- I is issued in the ISSUE following D's completion.
REQ-020 Both requesters held pending continuously: grants SHALL alternate D,I,D,I over 4 accesses.
REQ-021 Zero-wait memory (`mem_resp`=1 in ISSUE): each access completes in 2 cycles; back-to-back D requests are issued every 2 cycles.
REQ-022 Reset pulsed in WAIT, then `mem_resp`=1 two cycles after release: no resp output, state IDLE, mem masks 0.
REQ-023 `mem_resp`=1 with no request pending: no resp output, state stays IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/data requesters, the arbiter and the
// shared memory port. The arbiter uses the slave view; the environment
// (requesters plus memory model) uses the master view.
interface mem_port_arbiter_if;
  // instruction-fetch requester
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  // data requester
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  // shared memory port
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport slave (
    input  imem_addr, imem_rmask,
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  mem_rdata, mem_resp,
    output imem_rdata, imem_resp,
    output dmem_rdata, dmem_resp,
    output mem_addr, mem_rmask, mem_wmask, mem_wdata
  );

  modport master (
    output imem_addr, imem_rmask,
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output mem_rdata, mem_resp,
    input  imem_rdata, imem_resp,
    input  dmem_rdata, dmem_resp,
    input  mem_addr, mem_rmask, mem_wmask, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch, data) in front of one shared
// memory port. One access in flight at a time; ties resolved round-robin.
// Request fields are captured at grant so requesters may change them once
// their resp has been seen.
module mem_port_arbiter (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic       {GRANT_I, GRANT_D}  side_t;

  state_t      state;
  side_t       last_grant;   // also identifies the in-flight side in ISSUE/WAIT
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  out_rmask;    // captured masks, nonzero only during ISSUE
  logic [3:0]  out_wmask;

  logic i_pend;
  logic d_pend;
  logic grant_d;
  logic done;

  assign i_pend = |bus.imem_rmask;
  assign d_pend = |(bus.dmem_rmask | bus.dmem_wmask);

  // Round-robin: on a tie, serve the side that was not granted last.
  always_comb begin
    grant_d = d_pend && (!i_pend || (last_grant == GRANT_I));
  end

  // An access completes when memory responds while one is outstanding;
  // a stray mem_resp in IDLE is dropped here.
  assign done = (state != IDLE) && bus.mem_resp;

  // Grant/issue/wait sequencing with request capture and registered masks.
  // NOTE: reset is in the sensitivity list so the port goes quiet the moment
  // rst rises, abandoning any access without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      out_rmask  <= '0;
      out_wmask  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this
      // block based on pre-edge values, independent of statement order.
      case (state)
        IDLE: begin
          if (i_pend || d_pend) begin
            state <= ISSUE;
            if (grant_d) begin
              last_grant <= GRANT_D;
              cap_addr   <= bus.dmem_addr;
              cap_wdata  <= bus.dmem_wdata;
              out_rmask  <= bus.dmem_rmask;
              out_wmask  <= bus.dmem_wmask;
            end else begin
              last_grant <= GRANT_I;
              cap_addr   <= bus.imem_addr;
              cap_wdata  <= '0;
              out_rmask  <= bus.imem_rmask;
              out_wmask  <= '0;
            end
          end
        end
        ISSUE: begin
          out_rmask <= '0;
          out_wmask <= '0;
          state     <= bus.mem_resp ? IDLE : WAIT;
        end
        WAIT: begin
          if (bus.mem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr   = cap_addr;
  assign bus.mem_wdata  = cap_wdata;
  assign bus.mem_rmask  = out_rmask;
  assign bus.mem_wmask  = out_wmask;

  assign bus.imem_rdata = bus.mem_rdata;
  assign bus.dmem_rdata = bus.mem_rdata;
  assign bus.imem_resp  = done && (last_grant == GRANT_I);
  assign bus.dmem_resp  = done && (last_grant == GRANT_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Expected shared-port issues are queued
// as each request is driven and popped when the port shows a nonzero mask;
// the popped entry then names the side that must see resp.
module tb_mem_port_arbiter;

  typedef enum logic {SIDE_I, SIDE_D} side_t;

  typedef struct {
    side_t       side;
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    int          at;
  } issue_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int     vectors     = 0;
  int     miscompares = 0;
  int     cycle       = 0;
  issue_t exp_q[$];
  logic   inflight    = 1'b0;
  side_t  inflight_side = SIDE_I;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic expect_issue(input side_t side, input logic [31:0] addr,
                              input logic [3:0] rmask, input logic [3:0] wmask,
                              input logic [31:0] wdata, input int at);
    issue_t e;
    e.side  = side;
    e.addr  = addr;
    e.rmask = rmask;
    e.wmask = wmask;
    e.wdata = wdata;
    e.at    = at;
    exp_q.push_back(e);
  endtask

  // Inputs for the current cycle are already driven (at the negedge); sample
  // outputs 1ns later, score them, then advance to the next negedge.
  task automatic cyc();
    issue_t e;
    logic   exp_i;
    logic   exp_d;
    #1;
    check("imem_rdata", bus.imem_rdata, bus.mem_rdata);
    check("dmem_rdata", bus.dmem_rdata, bus.mem_rdata);
    if ((bus.mem_rmask | bus.mem_wmask) != 4'h0) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_issue: observed rmask %h wmask %h expected none (cycle %0d)",
               bus.mem_rmask, bus.mem_wmask, cycle);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("issue_cycle", cycle, e.at);
        check("issue_addr", bus.mem_addr, e.addr);
        check("issue_rmask", {28'h0, bus.mem_rmask}, {28'h0, e.rmask});
        check("issue_wmask", {28'h0, bus.mem_wmask}, {28'h0, e.wmask});
        if (e.side == SIDE_D) check("issue_wdata", bus.mem_wdata, e.wdata);
        inflight      = 1'b1;
        inflight_side = e.side;
      end
    end
    exp_i = inflight && bus.mem_resp && (inflight_side == SIDE_I);
    exp_d = inflight && bus.mem_resp && (inflight_side == SIDE_D);
    check("imem_resp", {31'h0, bus.imem_resp}, {31'h0, exp_i});
    check("dmem_resp", {31'h0, bus.dmem_resp}, {31'h0, exp_d});
    if (inflight && bus.mem_resp) inflight = 1'b0;
    @(negedge clk);
    cycle++;
  endtask

  // Assert reset mid-cycle and check the outputs clear without a clock edge.
  task automatic apply_reset();
    rst      = 1'b1;
    inflight = 1'b0;
    #1;
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_mem_rmask", {28'h0, bus.mem_rmask}, 32'h0);
    check("rst_mem_wmask", {28'h0, bus.mem_wmask}, 32'h0);
    check("rst_imem_resp", {31'h0, bus.imem_resp}, 32'h0);
    check("rst_dmem_resp", {31'h0, bus.dmem_resp}, 32'h0);
    @(negedge clk);
    cycle++;
    rst = 1'b0;
  endtask

  initial begin
    int s;
    bus.imem_addr  = '0;
    bus.imem_rmask = '0;
    bus.dmem_addr  = '0;
    bus.dmem_rmask = '0;
    bus.dmem_wmask = '0;
    bus.dmem_wdata = '0;
    bus.mem_rdata  = '0;
    bus.mem_resp   = 1'b0;
    @(negedge clk);
    apply_reset();

    // Single fetch, memory answers three cycles after ISSUE.
    s = cycle;
    bus.imem_addr  = 32'h6000_0000;
    bus.imem_rmask = 4'hF;
    expect_issue(SIDE_I, 32'h6000_0000, 4'hF, 4'h0, 32'h0, s + 1);
    cyc(); cyc(); cyc(); cyc();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'h0000_0013;
    cyc();
    bus.mem_resp   = 1'b0;
    bus.imem_rmask = 4'h0;
    cyc();

    // Simultaneous I and D straight after reset: D first, then I.
    apply_reset();
    s = cycle;
    bus.dmem_addr  = 32'h0000_0100;
    bus.dmem_wmask = 4'h3;
    bus.dmem_wdata = 32'h0000_BEEF;
    bus.imem_addr  = 32'h6000_0004;
    bus.imem_rmask = 4'hF;
    expect_issue(SIDE_D, 32'h0000_0100, 4'h0, 4'h3, 32'h0000_BEEF, s + 1);
    expect_issue(SIDE_I, 32'h6000_0004, 4'hF, 4'h0, 32'h0, s + 4);
    cyc(); cyc();
    bus.mem_resp = 1'b1;
    cyc();
    bus.mem_resp   = 1'b0;
    bus.dmem_wmask = 4'h0;
    cyc(); cyc();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    cyc();
    bus.mem_resp   = 1'b0;
    bus.imem_rmask = 4'h0;
    cyc();

    // Both held pending: grants alternate D, I, D, I.
    s = cycle;
    bus.dmem_addr  = 32'h0000_0400;
    bus.dmem_rmask = 4'hF;
    bus.dmem_wdata = 32'h0;
    bus.imem_addr  = 32'h6000_0040;
    bus.imem_rmask = 4'hF;
    expect_issue(SIDE_D, 32'h0000_0400, 4'hF, 4'h0, 32'h0, s + 1);
    expect_issue(SIDE_I, 32'h6000_0040, 4'hF, 4'h0, 32'h0, s + 4);
    expect_issue(SIDE_D, 32'h0000_0400, 4'hF, 4'h0, 32'h0, s + 7);
    expect_issue(SIDE_I, 32'h6000_0040, 4'hF, 4'h0, 32'h0, s + 10);
    for (int k = 0; k < 12; k++) begin
      bus.mem_resp  = (k % 3 == 2);
      bus.mem_rdata = 32'hA000_0000 + k;
      cyc();
    end
    bus.mem_resp   = 1'b0;
    bus.dmem_rmask = 4'h0;
    bus.imem_rmask = 4'h0;
    cyc();

    // Zero-wait memory, D back-to-back with read and write masks together.
    s = cycle;
    bus.dmem_addr  = 32'h0000_0200;
    bus.dmem_rmask = 4'h1;
    bus.dmem_wmask = 4'h2;
    bus.dmem_wdata = 32'h1234_5678;
    bus.mem_resp   = 1'b1;
    for (int k = 0; k < 3; k++)
      expect_issue(SIDE_D, 32'h0000_0200, 4'h1, 4'h2, 32'h1234_5678, s + 1 + 2 * k);
    for (int k = 0; k < 6; k++) begin
      bus.mem_rdata = 32'hC000_0000 + k;
      cyc();
    end
    bus.mem_resp   = 1'b0;
    bus.dmem_rmask = 4'h0;
    bus.dmem_wmask = 4'h0;
    cyc();

    // Reset during WAIT; a late mem_resp for the dropped access is ignored.
    s = cycle;
    bus.imem_addr  = 32'h6000_0100;
    bus.imem_rmask = 4'hF;
    expect_issue(SIDE_I, 32'h6000_0100, 4'hF, 4'h0, 32'h0, s + 1);
    cyc(); cyc(); cyc();
    bus.imem_rmask = 4'h0;
    apply_reset();
    cyc(); cyc();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'hDEAD_0001;
    cyc();
    bus.mem_resp = 1'b0;
    // A fresh fetch must be issued one cycle later, proving the FSM is in IDLE.
    s = cycle;
    bus.imem_addr  = 32'h6000_0200;
    bus.imem_rmask = 4'hF;
    expect_issue(SIDE_I, 32'h6000_0200, 4'hF, 4'h0, 32'h0, s + 1);
    cyc();
    bus.mem_resp = 1'b1;
    cyc();
    bus.mem_resp   = 1'b0;
    bus.imem_rmask = 4'h0;
    cyc();

    // Stray mem_resp with nothing pending, then a request granted normally.
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'h5555_AAAA;
    cyc(); cyc(); cyc();
    s = cycle;
    bus.dmem_addr  = 32'h0000_0300;
    bus.dmem_rmask = 4'hF;
    expect_issue(SIDE_D, 32'h0000_0300, 4'hF, 4'h0, 32'h1234_5678, s + 1);
    cyc(); cyc();
    bus.mem_resp   = 1'b0;
    bus.dmem_rmask = 4'h0;
    cyc(); cyc();

    check("issue_queue_empty", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
